axi_read_arbiter: RTL

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

---
 rtl/axi_rd_arb_pkg.sv | 14 +
 rtl/rd_outstanding_ctr.sv | 30 +++
 rtl/axi_read_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arb_pkg.sv
// Shared encodings and sizes for the two-master AXI read-address arbiter.
// Build option AXI_RD_ARB_OUTSTANDING_LIMIT_EN is consumed by axi_read_arbiter.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_t;

    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int CNT_W               = 3;

endpackage

// File: rtl/rd_outstanding_ctr.sv
// Per-master outstanding-burst counter; saturates at all-ones, holds at zero.
// Zero latency on o_underflow (pulse), count updates on the next rising edge.
module rd_outstanding_ctr
    import axi_rd_arb_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_underflow
);

    logic [CNT_W-1:0] r_count;

    // A simultaneous inc and dec cancel, so only a net decrement can underflow.
    assign o_underflow = i_dec & ~i_inc & (r_count == '0);
    assign o_count     = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            if (r_count != '1) r_count <= r_count + CNT_W'(1);
        end else if (i_dec && !i_inc) begin
            if (r_count != '0) r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin AR arbiter for two masters onto one slave, with ID-based R routing.
// AR: 1-cycle grant latency, grant held until handshake; R: combinational. Option: AXI_RD_ARB_OUTSTANDING_LIMIT_EN.
module axi_read_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int BusWidth        = 32,
    parameter int tagbits         = 1,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                m0_ARVALID,
    input  logic [tagbits-1:0]  m0_ARID,
    input  logic [BusWidth-1:0] m0_ARADDR,
    input  logic [3:0]          m0_ARLEN,
    input  logic [1:0]          m0_ARSIZE,
    input  logic [1:0]          m0_ARBURST,
    input  logic [1:0]          m0_ARLOCK,
    input  logic [3:0]          m0_ARCACHE,
    input  logic [2:0]          m0_ARPROT,
    output logic                m0_ARREADY,
    input  logic                m1_ARVALID,
    input  logic [tagbits-1:0]  m1_ARID,
    input  logic [BusWidth-1:0] m1_ARADDR,
    input  logic [3:0]          m1_ARLEN,
    input  logic [1:0]          m1_ARSIZE,
    input  logic [1:0]          m1_ARBURST,
    input  logic [1:0]          m1_ARLOCK,
    input  logic [3:0]          m1_ARCACHE,
    input  logic [2:0]          m1_ARPROT,
    output logic                m1_ARREADY,
    output logic                S_ARVALID,
    output logic [tagbits:0]    S_ARID,
    output logic [BusWidth-1:0] S_ARADDR,
    output logic [3:0]          S_ARLEN,
    output logic [1:0]          S_ARSIZE,
    output logic [1:0]          S_ARBURST,
    output logic [1:0]          S_ARLOCK,
    output logic [3:0]          S_ARCACHE,
    output logic [2:0]          S_ARPROT,
    input  logic                S_ARREADY,
    input  logic [tagbits:0]    S_RID,
    input  logic [BusWidth-1:0] S_RDATA,
    input  logic [1:0]          S_RRESP,
    input  logic                S_RLAST,
    input  logic                S_RVALID,
    output logic                S_RREADY,
    output logic [tagbits-1:0]  m0_RID,
    output logic [BusWidth-1:0] m0_RDATA,
    output logic [1:0]          m0_RRESP,
    output logic                m0_RLAST,
    output logic                m0_RVALID,
    input  logic                m0_RREADY,
    output logic [tagbits-1:0]  m1_RID,
    output logic [BusWidth-1:0] m1_RDATA,
    output logic [1:0]          m1_RRESP,
    output logic                m1_RLAST,
    output logic                m1_RVALID,
    input  logic                m1_RREADY,
    output logic [CNT_W-1:0]    m0_outstanding,
    output logic [CNT_W-1:0]    m1_outstanding,
    output logic                rlast_err
);

`ifdef AXI_RD_ARB_OUTSTANDING_LIMIT_EN
    localparam bit LimitEn = 1'b1;
`else
    localparam bit LimitEn = 1'b0;
`endif
    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

    arb_state_t r_state;
    logic       r_last_grant;
    logic       r_rlast_err;
    logic       w_elig0, w_elig1, w_ar_hs0, w_ar_hs1;
    logic       w_rsel, w_r_last_hs, w_dec0, w_dec1, w_uf0, w_uf1;

    assign w_elig0  = m0_ARVALID & ~(LimitEn & (m0_outstanding == MaxCnt));
    assign w_elig1  = m1_ARVALID & ~(LimitEn & (m1_outstanding == MaxCnt));
    assign w_ar_hs0 = (r_state == GRANT0) & m0_ARVALID & S_ARREADY;
    assign w_ar_hs1 = (r_state == GRANT1) & m1_ARVALID & S_ARREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_elig0 && w_elig1) r_state <= r_last_grant ? GRANT0 : GRANT1;
                    else if (w_elig0)       r_state <= GRANT0;
                    else if (w_elig1)       r_state <= GRANT1;
                end
                GRANT0: if (w_ar_hs0) begin
                    r_state      <= IDLE;
                    r_last_grant <= 1'b0;
                end
                GRANT1: if (w_ar_hs1) begin
                    r_state      <= IDLE;
                    r_last_grant <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // AR path follows the granted master directly; IDLE drives all zeros.
    always_comb begin
        S_ARVALID = 1'b0;  S_ARID    = '0;  S_ARADDR = '0;  S_ARLEN   = '0;
        S_ARSIZE  = '0;    S_ARBURST = '0;  S_ARLOCK = '0;  S_ARCACHE = '0;
        S_ARPROT  = '0;    m0_ARREADY = 1'b0;  m1_ARREADY = 1'b0;
        case (r_state)
            GRANT0: begin
                S_ARVALID = m0_ARVALID;  S_ARID    = {1'b0, m0_ARID};
                S_ARADDR  = m0_ARADDR;   S_ARLEN   = m0_ARLEN;
                S_ARSIZE  = m0_ARSIZE;   S_ARBURST = m0_ARBURST;
                S_ARLOCK  = m0_ARLOCK;   S_ARCACHE = m0_ARCACHE;
                S_ARPROT  = m0_ARPROT;   m0_ARREADY = S_ARREADY;
            end
            GRANT1: begin
                S_ARVALID = m1_ARVALID;  S_ARID    = {1'b1, m1_ARID};
                S_ARADDR  = m1_ARADDR;   S_ARLEN   = m1_ARLEN;
                S_ARSIZE  = m1_ARSIZE;   S_ARBURST = m1_ARBURST;
                S_ARLOCK  = m1_ARLOCK;   S_ARCACHE = m1_ARCACHE;
                S_ARPROT  = m1_ARPROT;   m1_ARREADY = S_ARREADY;
            end
            default: ;
        endcase
    end

    // The top RID bit names the master that issued the burst.
    assign w_rsel    = S_RID[tagbits];
    assign S_RREADY  = w_rsel ? m1_RREADY : m0_RREADY;
    assign m0_RID    = S_RID[tagbits-1:0];
    assign m1_RID    = S_RID[tagbits-1:0];
    assign m0_RDATA  = S_RDATA;
    assign m1_RDATA  = S_RDATA;
    assign m0_RRESP  = S_RRESP;
    assign m1_RRESP  = S_RRESP;
    assign m0_RLAST  = S_RLAST;
    assign m1_RLAST  = S_RLAST;
    assign m0_RVALID = S_RVALID & ~w_rsel;
    assign m1_RVALID = S_RVALID &  w_rsel;

    assign w_r_last_hs = S_RVALID & S_RREADY & S_RLAST;
    assign w_dec0      = w_r_last_hs & ~w_rsel;
    assign w_dec1      = w_r_last_hs &  w_rsel;

    rd_outstanding_ctr u_ctr0 (
        .i_clk(ACLK), .i_rst(ARESET), .i_inc(w_ar_hs0), .i_dec(w_dec0),
        .o_count(m0_outstanding), .o_underflow(w_uf0)
    );
    rd_outstanding_ctr u_ctr1 (
        .i_clk(ACLK), .i_rst(ARESET), .i_inc(w_ar_hs1), .i_dec(w_dec1),
        .o_count(m1_outstanding), .o_underflow(w_uf1)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET)              r_rlast_err <= 1'b0;
        else if (w_uf0 || w_uf1) r_rlast_err <= 1'b1;
    end
    assign rlast_err = r_rlast_err;

endmodule
